icache_dm: RTL and testbench

//   Direct-mapped, read-only instruction cache between the pipeline fetch port and the backing memory.
//   CPU side: icache_addr/icache_req/icache_data/icache_rdy. Memory side: single-word req/rdy bus.

---
 rtl/icache_dm.sv | 123 ++++++++++++
 tb/tb_icache_dm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache.
// A hit is answered combinationally in the same cycle as the request.
// A miss fills the whole line from memory, one word at a time starting at word 0,
// and the request that is still pending then hits on the return to IDLE.
module icache_dm #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_req,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy
);

  localparam int WO = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - 2 - WO - IW;
  localparam int LW = 30 - WO;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [TW-1:0]      r_tag  [NUM_LINES];
  logic [31:0]        r_data [NUM_LINES][LINE_WORDS];
  logic [WO-1:0]      r_beat;
  logic [LW-1:0]      r_lineAddr;
  logic               r_flushed;

  logic [WO-1:0]      w_word;
  logic [IW-1:0]      w_idx;
  logic [TW-1:0]      w_tag;
  logic [IW-1:0]      w_fillIdx;
  logic [TW-1:0]      w_fillTag;
  logic               w_hit;
  logic               w_beatDone;
  logic               w_lastBeat;
  logic               w_unusedByteBits;

  // The two byte-offset bits never select anything in a word-wide cache.
  assign w_unusedByteBits = ^icache_addr[1:0];

  assign w_word = icache_addr[WO+1:2];
  assign w_idx  = icache_addr[WO+IW+1:WO+2];
  assign w_tag  = icache_addr[31:WO+IW+2];

  // The latched line address carries both the index and the tag of the line being filled.
  assign w_fillIdx = r_lineAddr[IW-1:0];
  assign w_fillTag = r_lineAddr[LW-1:IW];

  assign w_beatDone = (r_state == FILL) && mem_rdy;
  assign w_lastBeat = w_beatDone && (r_beat == WO'(LINE_WORDS - 1));

  assign w_hit = icache_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag) && (r_state == IDLE);

  assign icache_rdy  = w_hit;
  assign icache_data = w_hit ? r_data[w_idx][w_word] : 32'h0;

  assign mem_req  = (r_state == FILL);
  assign mem_addr = mem_req ? {r_lineAddr, r_beat, 2'b00} : 32'h0;

  // Miss detection, beat sequencing, valid-bit maintenance and flush handling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_beat     <= '0;
      r_lineAddr <= '0;
      r_flushed  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end
          if (icache_req && !w_hit) begin
            r_lineAddr       <= icache_addr[31:WO+2];
            r_valid[w_idx]   <= 1'b0;
            r_beat           <= '0;
            r_flushed        <= 1'b0;
            r_state          <= FILL;
          end
        end
        FILL: begin
          if (flush) begin
            r_valid   <= '0;
            r_flushed <= 1'b1;
          end
          if (w_beatDone) begin
            r_beat <= r_beat + WO'(1);
          end
          if (w_lastBeat) begin
            r_beat    <= '0;
            r_flushed <= 1'b0;
            r_state   <= IDLE;
            if (!r_flushed && !flush) begin
              r_valid[w_fillIdx] <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data and tag storage is written only by fills and is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (w_beatDone) begin
      r_data[w_fillIdx][r_beat] <= mem_rdata;
    end
    if (w_lastBeat) begin
      r_tag[w_fillIdx] <= w_fillTag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed corner sequences, a table of
// lookups and a randomized run against a line-presence reference model.
module tb_icache_dm;

  logic        clock;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data;
  logic        icache_rdy;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  int checkCount = 0;
  int passCount  = 0;

  icache_dm #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .icache_addr (icache_addr),
    .icache_req  (icache_req),
    .icache_data (icache_data),
    .icache_rdy  (icache_rdy),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_rdata   (mem_rdata),
    .mem_rdy     (mem_rdy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Backing memory contents: a fixed bijective scramble of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) + 32'h0BAD_F00D;
  endfunction

  assign mem_rdata = memWord(mem_addr);

  typedef struct {
    logic [31:0] addr;
    bit          expectHit;
    int          stall;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Fill-phase checks: request asserted, address of the current beat, no CPU hit.
  task automatic checkFill(input string name, input logic [31:0] expAddr);
    checkOutput({name, " mem_req"}, {31'h0, mem_req}, 32'h1);
    checkOutput({name, " mem_addr"}, mem_addr, expAddr);
    checkOutput({name, " rdy"}, {31'h0, icache_rdy}, 32'h0);
  endtask

  // Full fetch transaction; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input int stall, input bit randStall,
                               input bit expectHit, input string name);
    logic [31:0] base;
    int s;
    base = {addr[31:4], 4'h0};
    icache_req  = 1'b1;
    icache_addr = addr;
    mem_rdy     = 1'b0;
    #4;
    if (expectHit) begin
      checkOutput({name, " hit rdy"}, {31'h0, icache_rdy}, 32'h1);
      checkOutput({name, " hit data"}, icache_data, memWord(addr));
      checkOutput({name, " hit mem_req"}, {31'h0, mem_req}, 32'h0);
      tick;
      icache_req = 1'b0;
      return;
    end
    checkOutput({name, " miss rdy"}, {31'h0, icache_rdy}, 32'h0);
    checkOutput({name, " miss data"}, icache_data, 32'h0);
    checkOutput({name, " miss mem_req"}, {31'h0, mem_req}, 32'h0);
    tick;
    for (int b = 0; b < 4; b++) begin
      s = randStall ? int'($urandom_range(0, stall)) : stall;
      for (int k = 0; k < s; k++) begin
        mem_rdy = 1'b0;
        #4;
        checkFill({name, " stall"}, base + 32'(4 * b));
        tick;
      end
      mem_rdy = 1'b1;
      #4;
      checkFill({name, " beat"}, base + 32'(4 * b));
      tick;
    end
    mem_rdy = 1'b0;
    #4;
    checkOutput({name, " post-fill mem_req"}, {31'h0, mem_req}, 32'h0);
    checkOutput({name, " post-fill rdy"}, {31'h0, icache_rdy}, 32'h1);
    checkOutput({name, " post-fill data"}, icache_data, memWord(addr));
    tick;
    icache_req = 1'b0;
  endtask

  task automatic flushPulse;
    flush = 1'b1;
    tick;
    flush = 1'b0;
  endtask

  vec_t vecs [9];
  bit          refValid [16];
  logic [27:0] refLine  [16];

  // Main test sequence.
  initial begin
    logic [31:0] addr;
    logic [5:0]  line;
    bit          expHit;

    reset       = 1'b1;
    icache_req  = 1'b1;
    icache_addr = 32'h100;
    flush       = 1'b0;
    mem_rdy     = 1'b1;
    #3;
    checkOutput("reset mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset rdy", {31'h0, icache_rdy}, 32'h0);
    checkOutput("reset data", icache_data, 32'h0);
    tick;
    tick;
    icache_req = 1'b0;
    mem_rdy    = 1'b0;
    reset      = 1'b0;

    $display("[TB] basic fill and hit");
    applyStimulus(32'h100, 0, 1'b0, 1'b0, "t1 0x100");
    applyStimulus(32'h10C, 0, 1'b0, 1'b1, "t1 0x10C");

    $display("[TB] conflict eviction");
    applyStimulus(32'h200, 0, 1'b0, 1'b0, "t2 0x200");
    applyStimulus(32'h100, 0, 1'b0, 1'b0, "t2 0x100 refill");

    $display("[TB] stalled memory");
    applyStimulus(32'h240, 3, 1'b0, 1'b0, "t3 0x240");
    applyStimulus(32'h248, 0, 1'b0, 1'b1, "t3 0x248");

    $display("[TB] flush during fill");
    icache_req  = 1'b1;
    icache_addr = 32'h300;
    mem_rdy     = 1'b1;
    #4;
    checkOutput("t4 miss rdy", {31'h0, icache_rdy}, 32'h0);
    tick;
    for (int b = 0; b < 4; b++) begin
      flush   = (b == 1);
      mem_rdy = 1'b1;
      #4;
      checkFill("t4 flushed fill", 32'h300 + 32'(4 * b));
      tick;
    end
    flush = 1'b0;
    applyStimulus(32'h300, 0, 1'b0, 1'b0, "t4 refetch");

    $display("[TB] async reset mid-fill");
    applyStimulus(32'h100, 0, 1'b0, 1'b0, "t5 prefill 0x100");
    applyStimulus(32'h104, 0, 1'b0, 1'b1, "t5 0x104");
    icache_req  = 1'b1;
    icache_addr = 32'h180;
    mem_rdy     = 1'b1;
    tick;
    for (int b = 0; b < 3; b++) begin
      #4;
      checkFill("t5 pre-reset", 32'h180 + 32'(4 * b));
      tick;
    end
    reset = 1'b1;
    #1;
    checkOutput("t5 reset mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("t5 reset mem_addr", mem_addr, 32'h0);
    icache_req = 1'b0;
    mem_rdy    = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    applyStimulus(32'h100, 0, 1'b0, 1'b0, "t5 post-reset 0x100");

    $display("[TB] flush in IDLE and address change mid-fill");
    icache_req  = 1'b1;
    icache_addr = 32'h100;
    flush       = 1'b1;
    mem_rdy     = 1'b0;
    #4;
    checkOutput("t6 flush same-cycle rdy", {31'h0, icache_rdy}, 32'h1);
    checkOutput("t6 flush same-cycle data", icache_data, memWord(32'h100));
    tick;
    flush = 1'b0;
    #4;
    checkOutput("t6 after flush rdy", {31'h0, icache_rdy}, 32'h0);
    tick;
    for (int b = 0; b < 4; b++) begin
      mem_rdy = 1'b1;
      if (b == 2) icache_addr = 32'h140;
      #4;
      checkFill("t6 fill 0x100", 32'h100 + 32'(4 * b));
      tick;
    end
    applyStimulus(32'h140, 0, 1'b0, 1'b0, "t6 0x140 miss");
    applyStimulus(32'h100, 0, 1'b0, 1'b1, "t6 0x100 hit");
    applyStimulus(32'h140, 0, 1'b0, 1'b1, "t6 0x140 hit");

    $display("[TB] table of lookups");
    vecs[0] = '{32'h104,  1'b1, 0};
    vecs[1] = '{32'h10B,  1'b1, 0};
    vecs[2] = '{32'h14C,  1'b1, 0};
    vecs[3] = '{32'h1100, 1'b0, 1};
    vecs[4] = '{32'h100,  1'b0, 0};
    vecs[5] = '{32'h1104, 1'b0, 2};
    vecs[6] = '{32'h2C0,  1'b0, 0};
    vecs[7] = '{32'h2C8,  1'b1, 0};
    vecs[8] = '{32'h144,  1'b1, 0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].stall, 1'b0, vecs[i].expectHit, $sformatf("vec%0d", i));
    end

    $display("[TB] randomized against reference model");
    flushPulse;
    for (int i = 0; i < 16; i++) refValid[i] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        flushPulse;
        for (int i = 0; i < 16; i++) refValid[i] = 1'b0;
      end
      line   = 6'($urandom_range(0, 63));
      addr   = {22'h0, line, 4'h0} | 32'($urandom_range(0, 15));
      expHit = refValid[line[3:0]] && (refLine[line[3:0]] == {22'h0, line});
      applyStimulus(addr, 2, 1'b1, expHit, $sformatf("rand%0d", n));
      refValid[line[3:0]] = 1'b1;
      refLine[line[3:0]]  = {22'h0, line};
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
